// File: rtl/pio_bus_pkg.sv
// Shared state encoding, default geometry and timing for the PIO bus master and its peripherals.
package pio_bus_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StStrobe = 2'd2,
    StHold   = 2'd3
  } pio_state_e;

  localparam int unsigned DefAddrW     = 2;
  localparam int unsigned DefDataW     = 8;
  localparam int unsigned DefSetupCyc  = 1;
  localparam int unsigned DefStrobeCyc = 2;
  localparam int unsigned DefHoldCyc   = 1;
  localparam int unsigned StallLimit   = 255;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pio_bus_timer.sv
// Loadable down-counter timing one bus phase; done_o is high while the count is zero.
module pio_bus_timer #(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pio_bus_master.sv
// PIO bus initiator: one valid/ready request becomes a setup/strobe/hold bus cycle.
// Optional PIO_MASTER_WAIT_EN adds bus_wait_n_i strobe stretching and rsp_err_o on stall timeout.
module pio_bus_master
  import pio_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned SETUP_CYC  = DefSetupCyc,
  parameter int unsigned STROBE_CYC = DefStrobeCyc,
  parameter int unsigned HOLD_CYC   = DefHoldCyc
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              cs_n_o,
  output logic              we_n_o,
  output logic              oe_n_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_tx_o,
`ifdef PIO_MASTER_WAIT_EN
  input  logic              bus_wait_n_i,
  output logic              rsp_err_o,
`endif
  input  logic [DATA_W-1:0] data_rx_i
);

  localparam int unsigned TimerW = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);
  localparam logic [TimerW-1:0] SetupLd  = TimerW'(SETUP_CYC - 1);
  localparam logic [TimerW-1:0] StrobeLd = TimerW'(STROBE_CYC - 1);
  localparam logic [TimerW-1:0] HoldLd   = TimerW'(HOLD_CYC - 1);

  pio_state_e        state_q, state_d;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rdata_q;
  logic              cs_n_q, we_n_q, oe_n_q;
  logic              rsp_valid_q, rsp_valid_d;
  logic              tmr_load, tmr_done, leave_strobe, accept;
  logic [TimerW-1:0] tmr_val;

`ifdef PIO_MASTER_WAIT_EN
  localparam logic [7:0] StallMax = 8'(StallLimit);
  logic [7:0] stall_q, stall_d;
  logic       err_q;
`endif

  pio_bus_timer #(
    .Width (TimerW)
  ) u_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  assign accept = (state_q == StIdle) && req_valid_i;

  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    leave_strobe = 1'b0;
    rsp_valid_d  = 1'b0;
`ifdef PIO_MASTER_WAIT_EN
    stall_d      = stall_q;
`endif
    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          state_d  = StSetup;
          tmr_load = 1'b1;
          tmr_val  = SetupLd;
        end
      end
      StSetup: begin
        if (tmr_done) begin
          state_d  = StStrobe;
          tmr_load = 1'b1;
          tmr_val  = StrobeLd;
        end
      end
      StStrobe: begin
        if (tmr_done) begin
`ifdef PIO_MASTER_WAIT_EN
          // Stretch the final strobe cycle while the peripheral holds wait low.
          if (!bus_wait_n_i && (stall_q != StallMax)) begin
            stall_d = stall_q + 1'b1;
          end else begin
            leave_strobe = 1'b1;
            stall_d      = '0;
          end
`else
          leave_strobe = 1'b1;
`endif
        end
      end
      StHold: begin
        if (tmr_done) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (leave_strobe) begin
      state_d  = StHold;
      tmr_load = 1'b1;
      tmr_val  = HoldLd;
    end
  end

  // Strobes are registered from the next state so the pins never glitch.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      write_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
      cs_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_n_q      <= (state_d != StStrobe);
      we_n_q      <= !((state_d == StStrobe) && write_q);
      oe_n_q      <= !((state_d == StStrobe) && !write_q);
      rsp_valid_q <= rsp_valid_d;
      if (accept) begin
        write_q <= req_write_i;
        addr_q  <= req_addr_i;
        data_q  <= req_wdata_i;
      end
      if (leave_strobe && !write_q) begin
        rdata_q <= data_rx_i;
      end
    end
  end

`ifdef PIO_MASTER_WAIT_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      if (accept) begin
        err_q <= 1'b0;
      end else if (leave_strobe) begin
        err_q <= !bus_wait_n_i;
      end
    end
  end

  assign rsp_err_o = rsp_valid_q & err_q;
`endif

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign cs_n_o      = cs_n_q;
  assign we_n_o      = we_n_q;
  assign oe_n_o      = oe_n_q;
  assign addr_o      = addr_q;
  assign data_tx_o   = data_q;

endmodule

// File: tb/tb_pio_bus_master.sv
// Scoreboard bench for pio_bus_master: default-timing instance plus a 3/4/2 timing instance.
module tb_pio_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       req_valid, req_ready, req_write, rsp_valid, cs_n, we_n, oe_n;
  logic [1:0] req_addr, addr;
  logic [7:0] req_wdata, rsp_rdata, data_tx, data_rx;

  logic       b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_cs_n, b_we_n, b_oe_n;
  logic [1:0] b_req_addr, b_addr;
  logic [7:0] b_req_wdata, b_rsp_rdata, b_data_tx, b_rx;

`ifdef PIO_MASTER_WAIT_EN
  logic err_a, err_b;
`endif

  pio_bus_master #(
    .ADDR_W(2), .DATA_W(8), .SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1)
  ) u_dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .cs_n_o      (cs_n),
    .we_n_o      (we_n),
    .oe_n_o      (oe_n),
    .addr_o      (addr),
    .data_tx_o   (data_tx),
`ifdef PIO_MASTER_WAIT_EN
    .bus_wait_n_i(1'b1),
    .rsp_err_o   (err_a),
`endif
    .data_rx_i   (data_rx)
  );

  pio_bus_master #(
    .ADDR_W(2), .DATA_W(8), .SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2)
  ) u_dut_slow (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_valid_i (b_req_valid),
    .req_ready_o (b_req_ready),
    .req_write_i (b_req_write),
    .req_addr_i  (b_req_addr),
    .req_wdata_i (b_req_wdata),
    .rsp_valid_o (b_rsp_valid),
    .rsp_rdata_o (b_rsp_rdata),
    .cs_n_o      (b_cs_n),
    .we_n_o      (b_we_n),
    .oe_n_o      (b_oe_n),
    .addr_o      (b_addr),
    .data_tx_o   (b_data_tx),
`ifdef PIO_MASTER_WAIT_EN
    .bus_wait_n_i(1'b1),
    .rsp_err_o   (err_b),
`endif
    .data_rx_i   (b_rx)
  );

  typedef struct {
    bit          w;
    bit [1:0]    a;
    bit [7:0]    wd;
    bit [7:0]    rd;
    bit          frc;
    bit [7:0]    fv;
    int unsigned acc;
  } exp_t;

  exp_t q[$];
  exp_t qb[$];

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Simple io peripheral: four registers, porta is register 0.
  logic [7:0] periph [4] = '{default: 8'h00};
  logic [7:0] model  [4] = '{default: 8'h00};
  logic [7:0] last_rd = 8'h00;
  logic [7:0] rx_drive = 8'h00;
  wire  [7:0] porta = periph[0];
  assign data_rx = rx_drive;

  always @(posedge clk) if (!cs_n && !we_n) periph[addr] <= data_tx;

  int unsigned cs_cnt = 0, we_cnt = 0, oe_cnt = 0;
  bit          bad_bus = 0;
  exp_t        me;

  always @(negedge clk) begin
    if (reset) begin
      cs_cnt = 0; we_cnt = 0; oe_cnt = 0; bad_bus = 0;
    end else begin
      if (!cs_n) cs_cnt++;
      if (!we_n) we_cnt++;
      if (!oe_n) oe_cnt++;
      if (!we_n && !oe_n) bad_bus = 1;
      if (!cs_n && q.size() > 0)
        if (addr != q[0].a || (q[0].w && data_tx != q[0].wd)) bad_bus = 1;
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          me = q.pop_front();
          chk("rdata", rsp_rdata, me.rd);
          chk("latency", cyc - me.acc, 5);
          chk("cs_len", cs_cnt, 2);
          chk("we_len", we_cnt, me.w ? 2 : 0);
          chk("oe_len", oe_cnt, me.w ? 0 : 2);
          chk("bus_addr_data", bad_bus, 0);
          if (me.w) chk("periph_reg", periph[me.a], me.wd);
        end
        cs_cnt = 0; we_cnt = 0; oe_cnt = 0; bad_bus = 0;
      end
    end
    rx_drive = (q.size() > 0 && q[0].frc) ? q[0].fv : periph[addr];
  end

  int unsigned b_cs_cnt = 0;
  exp_t        mb;
  always @(negedge clk) begin
    if (reset) begin
      b_cs_cnt = 0;
    end else begin
      if (!b_cs_n) b_cs_cnt++;
      if (b_rsp_valid) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_rsp", 1, 0);
        end else begin
          mb = qb.pop_front();
          chk("b_latency", cyc - mb.acc, 10);
          chk("b_strobe_len", b_cs_cnt, 4);
          chk("b_rdata", b_rsp_rdata, mb.rd);
        end
        b_cs_cnt = 0;
      end
    end
  end

  bit held = 0;

  task automatic issue(input bit w, input bit [1:0] a, input bit [7:0] wd, input bit frc,
                       input bit [7:0] fv);
    exp_t e;
    int   n = 0;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = wd;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 0;
      held = 0;
      return;
    end
    if (held) chk("b2b_accept_in_rsp_cycle", rsp_valid, 1);
    e.w = w; e.a = a; e.wd = wd; e.frc = frc; e.fv = fv; e.acc = cyc;
    if (w) begin
      model[a] = wd;
      e.rd = last_rd;
    end else begin
      e.rd = frc ? fv : model[a];
      last_rd = e.rd;
    end
    q.push_back(e);
    @(negedge clk);
    held = 1;
  endtask

  task automatic idle(input int n);
    req_valid = 0;
    held = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  logic [7:0] last_rd_b = 8'h00;

  task automatic issue_b(input bit w, input bit [1:0] a, input bit [7:0] wd, input bit [7:0] fv);
    exp_t e;
    int   n = 0;
    b_req_valid = 1; b_req_write = w; b_req_addr = a; b_req_wdata = wd; b_rx = fv;
    while (!b_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!b_req_ready) begin
      chk("b_accept_timeout", 0, 1);
      b_req_valid = 0;
      return;
    end
    e.w = w; e.a = a; e.wd = wd; e.frc = 1; e.fv = fv; e.acc = cyc;
    if (!w) last_rd_b = fv;
    e.rd = last_rd_b;
    qb.push_back(e);
    @(negedge clk);
    b_req_valid = 0;
    n = 0;
    while (qb.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b_drain", qb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_rx = 0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_we_n", we_n, 1);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_addr", addr, 0);
    chk("rst_data_tx", data_tx, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    reset = 0;
    @(negedge clk);

    issue(1, 2'd0, 8'hFF, 0, 8'h00);
    idle(4);
    chk("porta_ff", porta, 8'hFF);
    issue(1, 2'd0, 8'h00, 0, 8'h00);
    issue(1, 2'd0, 8'hFF, 0, 8'h00);
    issue(1, 2'd0, 8'h00, 0, 8'h00);
    idle(6);
    issue(0, 2'd1, 8'h00, 1, 8'hA5);
    idle(6);

    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 8'($urandom),
            1'($urandom_range(1, 0)), 8'($urandom));
      if ($urandom_range(1, 0) == 1) idle($urandom_range(5, 0));
    end
    idle(2);
    drain();

    // Abort a read in the middle of its strobe.
    issue(0, 2'd2, 8'h00, 1, 8'h3C);
    req_valid = 0;
    held = 0;
    n = 0;
    while (cs_n && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reached_strobe", cs_n, 0);
    reset = 1;
    @(negedge clk);
    chk("abort_cs_n", cs_n, 1);
    chk("abort_we_n", we_n, 1);
    chk("abort_oe_n", oe_n, 1);
    chk("abort_ready", req_ready, 1);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_rsp_rdata", rsp_rdata, 0);
    q.delete();
    last_rd = 8'h00;
    reset = 0;
    idle(10);

    issue(0, 2'd0, 8'h00, 0, 8'h00);
    issue(1, 2'd3, 8'h5A, 0, 8'h00);
    issue(0, 2'd3, 8'h00, 0, 8'h00);
    idle(2);
    drain();

    issue_b(1, 2'd1, 8'h77, 8'h00);
    for (int i = 0; i < 6; i++) begin
      issue_b(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 8'($urandom), 8'($urandom));
    end
    issue_b(0, 2'd2, 8'h00, 8'hC3);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
